// File: rtl/bin_rnd_buffer_if.sv
// Handshake bundle between the PRNG, the randomness buffer and the gadget pipeline.
// The buffer takes the slave modport; whoever drives the PRNG side and consumes words uses master.
interface bin_rnd_buffer_if #(
    parameter int unsigned W         = 1,
    parameter int unsigned LOG_DEPTH = 2
);
    logic [W-1:0]       in_data;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       out_data;
    logic               out_valid;
    logic               out_ready;
    logic [LOG_DEPTH:0] level;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output level
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  level
    );
endinterface

// File: rtl/bin_rnd_buffer_mem.sv
// DEPTH x W register array holding buffered random words; one write port, async read port.
// Kept as its own hierarchy so randomness storage is never merged with gadget logic.
(* keep_hierarchy = "yes" *)
module bin_rnd_buffer_mem #(
    parameter int unsigned W         = 1,
    parameter int unsigned LOG_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [LOG_DEPTH-1:0] waddr_i,
    input  logic [W-1:0]         wdata_i,
    input  logic [LOG_DEPTH-1:0] raddr_i,
    output logic [W-1:0]         rdata_o
);
    localparam int unsigned Depth = 1 << LOG_DEPTH;

    logic [W-1:0] mem_q [Depth];

    // Contents are deliberately not reset; validity is tracked by the level counter.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/bin_rnd_buffer.sv
// First-word-fall-through elastic buffer for fresh randomness between PRNG and masked gadgets.
// All outputs come straight from registers so nothing on in_* reaches out_* combinationally.
module bin_rnd_buffer #(
    parameter int unsigned W         = 1,
    parameter int unsigned LOG_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    bin_rnd_buffer_if.slave  bus
);
    localparam int unsigned LvlW      = LOG_DEPTH + 1;
    localparam logic [LvlW-1:0] LvlFull = LvlW'(1 << LOG_DEPTH);
    localparam logic [LvlW-1:0] LvlOne  = LvlW'(1);

    logic [LOG_DEPTH-1:0] wptr_q, wptr_d;
    logic [LOG_DEPTH-1:0] rptr_q, rptr_d;
    logic [LvlW-1:0]      level_q, level_d;
    logic [W-1:0]         out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;

    logic                 push;
    logic                 pop;
    logic                 mem_we;
    logic [LOG_DEPTH-1:0] mem_raddr;
    logic [W-1:0]         mem_rdata;

    assign push      = bus.in_valid & in_ready_q;
    assign pop       = out_valid_q & bus.out_ready;
    assign mem_we    = push & ~flush;
    // The head word already sits in out_data_q; prefetch the one behind it.
    assign mem_raddr = rptr_q + 1'b1;

    bin_rnd_buffer_mem #(
        .W         (W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (wptr_q),
        .wdata_i (bus.in_data),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase

            // Head refill: from storage if another word is queued, else bypass the incoming word.
            if (pop && (level_q > LvlOne)) begin
                out_data_d = mem_rdata;
            end else if (push && ((level_q == '0) || (pop && (level_q == LvlOne)))) begin
                out_data_d = bus.in_data;
            end

            out_valid_d = (level_d != '0);
            in_ready_d  = (level_d != LvlFull);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.level     = level_q;
endmodule

// File: doc/bin_rnd_buffer.md
Name: bin_rnd_buffer

Overview:
- Elastic buffer for fresh randomness. It sits between the PRNG and the masked-gadget pipeline (pipeline registers and multiplication gadgets).
- It absorbs PRNG bursts and stalls, so gadgets consume one W-bit random word per enabled cycle with no combinational path from PRNG to gadget inputs.
- It is a first-word-fall-through FIFO with valid/ready on both sides, a synchronous flush and an occupancy output.

Parameters:
- W, 1, width of one random word in bits (>=1).
- LOG_DEPTH, 2, log2 of the number of storage entries (DEPTH = 2**LOG_DEPTH, LOG_DEPTH >= 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents; has priority over push and pop.
- in_data  in  W  random word from the PRNG.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  buffer can accept a word this cycle.
- out_data  out  W  random word to the gadgets.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer takes out_data this cycle.
- level  out  LOG_DEPTH+1  number of stored words, including the word presented on out_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=1, level=0, out_data=0.
  - Read/write pointers are 0.
  - Storage array is not reset.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready:
  - Registered; equals (level != DEPTH) as of the current state.
  - It never depends combinationally on out_ready, so there is no pop-through when full.
- out_valid, out_data and level are driven directly from registers. There is no combinational path from in_* to out_*; this is mandatory for glitch isolation of the randomness.
- Latency: a word pushed in cycle t on an empty buffer appears with out_valid=1 in cycle t+1. A push and a pop in the same cycle on an empty buffer cannot occur (out_valid=0).
- Ordering: strict FIFO; words leave in acceptance order. No word is duplicated or dropped.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - Neither: unchanged.
- Full (level=DEPTH): in_ready=0; in_valid is ignored. A pop in this cycle makes in_ready=1 next cycle.
- Empty (level=0): out_valid=0; out_ready is ignored. out_data holds its last value; consumers must not rely on it.
- Pointer wrap: read and write pointers are LOG_DEPTH bits and wrap modulo DEPTH. Full and empty are distinguished by level, not by pointer comparison.
- out_data update:
  - On a pop with level>=2, out_data loads the next entry in the same edge.
  - On a pop with level=1 and a simultaneous push, out_data loads in_data at that edge and out_valid stays 1.
- flush=1:
  - Next cycle: level=0, out_valid=0, in_ready=1, pointers=0, out_data=0.
  - A simultaneous push or pop has no effect.
- Reset mid-operation: all contents are lost immediately. After rst_n rises, the state is identical to post-reset.
- Single clock domain; no internal clock gating.

Decomposition:
- No shared package; all constants are local parameters derived from W and LOG_DEPTH.
- One natural sub-module: bin_rnd_buffer_mem.
  - DEPTH x W register array: write port (we, waddr, wdata), asynchronous read port (raddr, rdata).
  - Marked keep-hierarchy so synthesis does not merge randomness storage with gadget logic.
- The control logic (pointers, level, output register) lives in the top module.

Test Plan:
- Reset, then W=8, LOG_DEPTH=2: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles with out_ready=0 -> level 1,2,3,4. in_ready drops to 0 the cycle after the 4th push. out_data=0x11, out_valid=1 from cycle 1.
- Full buffer, in_valid=1 with data 0x55, out_ready=1 for one cycle -> 0x55 is not accepted that cycle. Next cycle level=3, in_ready=1, out_data=0x22.
- Continuous streaming with in_valid=out_ready=1 for 20 cycles over an incrementing sequence 0x00.. -> output sequence identical and gap-free after the 1-cycle fill latency; level constant at 1.
- Single entry (0xA5), pop with a simultaneous push of 0x5A -> out_valid stays 1, out_data=0x5A next cycle, level=1.
- Level 3, flush=1 with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, in_ready=1, out_data=0. A subsequent push of 0x77 appears after 1 cycle.
- Randomised stalls on both sides for 10k cycles, plus rst_n pulsed low asynchronously mid-burst -> scoreboard FIFO order holds, level never exceeds 4, outputs equal reset values while rst_n=0.
